// File: rtl/set_map_builder.sv
// set_map_builder: latches three circle descriptors on a start pulse, sweeps
// the 8x8 map one pixel per cycle and builds one 64-bit membership map per
// circle. Finished maps are read through three combinational indexed ports,
// and a one-cycle ctrl_en pulse starts the downstream counting controller.
module set_map_builder #(
    parameter int COORD_W = 4,
    parameter int MAP_DIM = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [6*COORD_W-1:0]   central,
    input  logic [3*COORD_W-1:0]   radius,
    input  logic [1:0]             mode,
    output logic [1:0]             reg_mode,
    input  logic [5:0]             idx_0,
    input  logic [5:0]             idx_1,
    input  logic [5:0]             idx_2,
    output logic                   bit_0,
    output logic                   bit_1,
    output logic                   bit_2,
    output logic                   busy,
    output logic                   map_valid,
    output logic                   ctrl_en
);

    localparam int NPIX  = MAP_DIM * MAP_DIM;
    localparam int PIX_W = $clog2(NPIX);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic                 start_s;
    logic [PIX_W-1:0]     pix_r;
    logic [NPIX-1:0]      map_r   [3];
    logic [COORD_W-1:0]   cx_r    [3];
    logic [COORD_W-1:0]   cy_r    [3];
    logic [COORD_W-1:0]   rad_r   [3];
    logic [1:0]           mode_r;
    logic                 busy_r;
    logic                 map_valid_r;
    logic                 ctrl_en_r;
    logic [2:0]           member_s;

    // Square of the distance along one axis. The magnitude of the difference
    // is taken first, which equals the square of the signed difference and
    // keeps the product unsigned.
    function automatic logic [2*COORD_W-1:0] sq_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W-1:0] mag;
        if (a >= b) begin
            mag = a - b;
        end else begin
            mag = b - a;
        end
        return {{COORD_W{1'b0}}, mag} * {{COORD_W{1'b0}}, mag};
    endfunction

    // Pixel (px+1, py+1) lies inside or on the circle of centre (cx, cy),
    // radius r. Centres outside 1..8 are evaluated unclamped.
    function automatic logic in_circle(
        input logic [2:0]         px,
        input logic [2:0]         py,
        input logic [COORD_W-1:0] cx,
        input logic [COORD_W-1:0] cy,
        input logic [COORD_W-1:0] r
    );
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [2*COORD_W:0]   dist2;
        logic [2*COORD_W-1:0] r2;
        x     = {{(COORD_W-3){1'b0}}, px} + {{(COORD_W-1){1'b0}}, 1'b1};
        y     = {{(COORD_W-3){1'b0}}, py} + {{(COORD_W-1){1'b0}}, 1'b1};
        dist2 = {1'b0, sq_diff(x, cx)} + {1'b0, sq_diff(y, cy)};
        r2    = {{COORD_W{1'b0}}, r} * {{COORD_W{1'b0}}, r};
        return (dist2 <= {1'b0, r2});
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a start is honoured only in IDLE or DONE.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (en) begin
                    start_s    = 1'b1;
                    state_nx_s = ST_BUILD;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_BUILD: begin
                if (pix_r == PIX_LAST) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUILD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Membership of the current pixel in each latched circle.
    always_comb begin
        member_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            member_s[k] = in_circle(pix_r[2:0], pix_r[5:3], cx_r[k], cy_r[k], rad_r[k]);
        end
    end

    // Descriptor latch, pixel sweep and map writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_r  <= {PIX_W{1'b0}};
            mode_r <= 2'b00;
            for (int k = 0; k < 3; k++) begin
                map_r[k] <= {NPIX{1'b0}};
                cx_r[k]  <= {COORD_W{1'b0}};
                cy_r[k]  <= {COORD_W{1'b0}};
                rad_r[k] <= {COORD_W{1'b0}};
            end
        end else if (start_s) begin
            pix_r  <= {PIX_W{1'b0}};
            mode_r <= mode;
            for (int k = 0; k < 3; k++) begin
                map_r[k] <= {NPIX{1'b0}};
                cx_r[k]  <= central[6*COORD_W-1-2*COORD_W*k -: COORD_W];
                cy_r[k]  <= central[5*COORD_W-1-2*COORD_W*k -: COORD_W];
                rad_r[k] <= radius[3*COORD_W-1-COORD_W*k -: COORD_W];
            end
        end else if (state_r == ST_BUILD) begin
            pix_r <= pix_r + PIX_ONE;
            for (int k = 0; k < 3; k++) begin
                map_r[k][pix_r] <= member_s[k];
            end
        end else begin
            pix_r <= pix_r;
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            map_valid_r <= 1'b0;
            ctrl_en_r   <= 1'b0;
        end else begin
            busy_r      <= (state_nx_s == ST_BUILD);
            map_valid_r <= (state_nx_s == ST_DONE);
            ctrl_en_r   <= (state_r == ST_BUILD) && (state_nx_s == ST_DONE);
        end
    end

    assign busy      = busy_r;
    assign map_valid = map_valid_r;
    assign ctrl_en   = ctrl_en_r;
    assign reg_mode  = mode_r;

    // Read ports are combinational and usable in every state.
    assign bit_0 = map_r[0][idx_0];
    assign bit_1 = map_r[1][idx_1];
    assign bit_2 = map_r[2][idx_2];

endmodule

// File: tb/tb_set_map_builder.sv
// Testbench for set_map_builder: randomized and directed builds, expected
// maps from a geometric reference model queued at start, compared by an
// independent monitor that sweeps the read ports when the DUT signals done.
`timescale 1ns/1ps
module tb_set_map_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [23:0] central = 24'h0;
    logic [11:0] radius = 12'h0;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  reg_mode;
    logic [5:0]  idx_0 = 6'd0;
    logic [5:0]  idx_1 = 6'd0;
    logic [5:0]  idx_2 = 6'd0;
    logic        bit_0, bit_1, bit_2;
    logic        busy, map_valid, ctrl_en;

    int checks = 0;
    int failures = 0;
    int issued = 0;
    int served = 0;
    int zreq = 0;

    typedef struct {
        logic [63:0] m0;
        logic [63:0] m1;
        logic [63:0] m2;
        logic [1:0]  md;
    } exp_t;
    exp_t exp_q[$];

    set_map_builder dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .reg_mode(reg_mode),
        .idx_0(idx_0), .idx_1(idx_1), .idx_2(idx_2),
        .bit_0(bit_0), .bit_1(bit_1), .bit_2(bit_2),
        .busy(busy), .map_valid(map_valid), .ctrl_en(ctrl_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: a pixel belongs to a circle when its Euclidean distance
    // squared to the centre is at most r squared.
    function automatic logic [63:0] ref_map(input int cx, input int cy, input int r);
        logic [63:0] m;
        m = 64'd0;
        for (int y = 1; y <= 8; y++) begin
            for (int x = 1; x <= 8; x++) begin
                if ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r)
                    m[(y - 1) * 8 + (x - 1)] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic exp_t make_exp(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        exp_t e;
        e.m0 = ref_map(int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
        e.m1 = ref_map(int'(c[15:12]), int'(c[11:8]),  int'(r[7:4]));
        e.m2 = ref_map(int'(c[7:4]),   int'(c[3:0]),   int'(r[3:0]));
        e.md = m;
        return e;
    endfunction

    task automatic wait_served();
        int n;
        n = 0;
        while (served != issued && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 64'(served), 64'(issued));
    endtask

    task automatic run_build(input logic [23:0] c, input logic [11:0] r,
                             input logic [1:0] m, input bit disturb);
        int bad;
        bad = 0;
        @(negedge clk);
        central = c; radius = r; mode = m; en = 1'b1;
        exp_q.push_back(make_exp(c, r, m));
        issued++;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) en = 1'b0;
            if (busy !== 1'b1 || map_valid !== 1'b0 || ctrl_en !== 1'b0) bad++;
            if (disturb && i == 10) begin
                en = 1'b1; central = ~c; radius = ~r; mode = 2'b01;
            end
            if (disturb && i == 11) en = 1'b0;
            if (i == 20) check("reg_mode_in_build", 64'(reg_mode), 64'(m));
        end
        check("busy_window_errors", 64'(bad), 64'd0);
        @(negedge clk);
        check("done_entry_flags", 64'({busy, map_valid, ctrl_en}), 64'(3'b011));
        @(negedge clk);
        check("ctrl_en_one_cycle", 64'({busy, map_valid, ctrl_en}), 64'(3'b010));
        wait_served();
    endtask

    task automatic request_zero_check();
        exp_t e;
        e.m0 = 64'd0; e.m1 = 64'd0; e.m2 = 64'd0; e.md = 2'b00;
        exp_q.push_back(e);
        issued++;
        zreq++;
        wait_served();
    endtask

    // Monitor: on ctrl_en (or a zero-check request) pop the expected maps and
    // sweep all 64 indices of the three read ports.
    initial begin
        exp_t e;
        logic [63:0] g0, g1, g2;
        int zdone;
        bit zero_hit;
        zdone = 0;
        forever begin
            @(negedge clk);
            zero_hit = (zreq != zdone);
            if (ctrl_en === 1'b1 || zero_hit) begin
                if (zero_hit) zdone++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ctrl_en", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("reg_mode_done", 64'(reg_mode), 64'(e.md));
                    g0 = 64'd0; g1 = 64'd0; g2 = 64'd0;
                    for (int i = 0; i < 64; i++) begin
                        idx_0 = 6'(i); idx_1 = 6'(i); idx_2 = 6'(i);
                        #1;
                        g0[i] = bit_0; g1[i] = bit_1; g2[i] = bit_2;
                        if (i < 63) @(negedge clk);
                    end
                    check("map_0", g0, e.m0);
                    check("map_1", g1, e.m1);
                    check("map_2", g2, e.m2);
                    served++;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [23:0] c;
        logic [11:0] r;
        repeat (3) @(negedge clk);
        check("reset_flags", 64'({busy, map_valid, ctrl_en}), 64'd0);
        check("reset_reg_mode", 64'(reg_mode), 64'd0);
        rst = 1'b1;
        request_zero_check();

        // c1 (4,4) r0, c2 (1,1) r1, c3 (4,4) r2; mode 10, disturbed mid-build
        run_build(24'h44_11_44, 12'h012, 2'b10, 1'b1);
        // restart from DONE: c1 full coverage, off-map centres for c2/c3
        run_build(24'h44_00_9F, 12'hF35, 2'b01, 1'b0);

        for (int n = 0; n < 6; n++) begin
            c = 24'($urandom);
            r = 12'($urandom);
            run_build(c, r, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        // reset part-way through a build
        @(negedge clk);
        central = 24'h55_33_77; radius = 12'h345; mode = 2'b11; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_flags", 64'({busy, map_valid, ctrl_en}), 64'd0);
        check("abort_reg_mode", 64'(reg_mode), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        request_zero_check();
        repeat (80) @(negedge clk);
        check("no_done_after_abort", 64'({busy, map_valid}), 64'd0);

        run_build(24'($urandom), 12'($urandom), 2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
